pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential / redirect / stall next-PC selection with bound
// and alignment checking. Optional return-address stack enabled by PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] PC_LIMIT  = XLEN'(1020),
    parameter int              RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           redir_valid,
    input  logic [XLEN-1:0]                redir_target,
    input  logic                           is_call,
    input  logic                           is_ret,
    output logic [XLEN-1:0]                pc,
    output logic                           fault,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] cand;
    logic            check;
    logic            viol;
    logic            ret_hit;
    logic [XLEN-1:0] ras_top;

    assign pc_seq = pc + XLEN'(4);

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   top_q;
    logic [PW-1:0]   top_pop;
    logic [PW-1:0]   top_next;
    logic [CW-1:0]   count_pop;
    logic [CW-1:0]   count_next;
    logic            push;

    // top_q is the next free slot; the circular wrap lets a push on a full stack
    // silently replace the oldest entry.
    always_comb begin
        ret_hit  = is_ret && (ras_count != '0);
        push     = is_call && redir_valid;
        top_pop  = top_q;
        if (ret_hit) begin
            top_pop = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - PW'(1);
        end
        ras_top  = ras_q[top_pop];
        top_next = top_pop;
        if (push) begin
            top_next = (top_pop == PW'(RAS_DEPTH - 1)) ? '0 : top_pop + PW'(1);
        end
        count_pop  = ras_count - CW'(ret_hit);
        count_next = count_pop;
        if (push && (count_pop != CW'(RAS_DEPTH))) begin
            count_next = count_pop + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            top_q     <= '0;
            ras_count <= '0;
        end else if (viol) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            top_q     <= '0;
            ras_count <= '0;
        end else begin
            if (push) ras_q[top_pop] <= pc_seq;
            top_q     <= top_next;
            ras_count <= count_next;
        end
    end
`else
    logic unused_ras;

    assign unused_ras = is_call ^ is_ret;
    assign ret_hit    = 1'b0;
    assign ras_top    = '0;
    assign ras_count  = '0;
`endif

    // A held PC was already checked when it was loaded, so stall skips the check.
    always_comb begin
        cand  = pc_seq;
        check = 1'b1;
        if (ret_hit) begin
            cand = ras_top;
        end else if (redir_valid) begin
            cand = redir_target;
        end else if (stall) begin
            cand  = pc;
            check = 1'b0;
        end
        viol = check && ((cand > PC_LIMIT) || (cand[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_VEC;
            fault <= 1'b0;
        end else if (viol) begin
            pc    <= RESET_VEC;
            fault <= 1'b1;
        end else begin
            pc    <= cand;
            fault <= 1'b0;
        end
    end

endmodule
